// File: rtl/conv3x3_frame_ctrl.sv
// conv3x3_frame_ctrl
//   Frame sequencer for the 3x3 streaming convolution engine. For each frame it
//   clears the engine, loads the 9 kernel weights, streams W*H raster pixels from
//   a 1-cycle-latency image RAM into the engine, counts (W-2)*(H-2) result beats
//   and then pulses done.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start, img_width/height     frame request and geometry (sampled in IDLE)
//   cfg_valid, cfg_data         kernel weight beats, k00 first, k22 last
//   kernel_flat                 weights to engine, k00 in the LSBs
//   hold                        source pause: suppresses reads this cycle
//   rd_en, rd_addr, rd_data     image RAM read port
//   conv_rst                    engine reset
//   conv_in_valid/pixel         pixel stream into the engine
//   conv_out_valid              engine result beat
//   busy, done, err, out_count  status
module conv3x3_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 20,
  parameter int DIM_W      = 16,
  parameter int CLR_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM_W-1:0]    img_width,
  input  logic [DIM_W-1:0]    img_height,
  input  logic                cfg_valid,
  input  logic [DATA_W-1:0]   cfg_data,
  output logic [9*DATA_W-1:0] kernel_flat,
  input  logic                hold,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                conv_rst,
  output logic                conv_in_valid,
  output logic [DATA_W-1:0]   conv_in_pixel,
  input  logic                conv_out_valid,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2*DIM_W-1:0]  out_count
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LOADK, STREAM, DRAIN, DONE} state_t;

  state_t             state;
  logic [DIM_W-1:0]   w_q, h_q;
  logic [3:0]         kidx;
  logic [CW-1:0]      clr_cnt;
  logic [2*DIM_W-1:0] total_px;
  logic [2*DIM_W-1:0] exp_cnt;
  logic               last_rd;

  // Products are formed at full 2*DIM_W width so no partial product is lost.
  assign total_px = (2*DIM_W)'(w_q) * (2*DIM_W)'(h_q);
  assign exp_cnt  = (2*DIM_W)'(w_q - DIM_W'(2)) * (2*DIM_W)'(h_q - DIM_W'(2));
  assign last_rd  = ((2*DIM_W)'(rd_addr) + (2*DIM_W)'(1)) == total_px;

  // hold must gate the read in the same cycle, so the strobe is decoded
  // straight from the registered state rather than registered itself.
  assign rd_en         = (state == STREAM) && !hold;
  assign conv_in_pixel = rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      w_q           <= '0;
      h_q           <= '0;
      kidx          <= '0;
      clr_cnt       <= '0;
      kernel_flat   <= '0;
      rd_addr       <= '0;
      conv_rst      <= 1'b1;
      conv_in_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      out_count     <= '0;
    end else begin
      done          <= 1'b0;
      err           <= 1'b0;
      conv_in_valid <= rd_en;   // RAM data lands one cycle after the strobe

      case (state)
        IDLE: begin
          conv_rst <= 1'b0;
          if (start) begin
            if (img_width >= DIM_W'(3) && img_height >= DIM_W'(3)) begin
              w_q       <= img_width;
              h_q       <= img_height;
              out_count <= '0;
              rd_addr   <= '0;
              kidx      <= '0;
              clr_cnt   <= '0;
              conv_rst  <= 1'b1;
              busy      <= 1'b1;
              state     <= CLEAR;
            end else begin
              err <= 1'b1;
            end
          end
        end

        CLEAR: begin
          if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
            conv_rst <= 1'b0;
            state    <= LOADK;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end

        LOADK: begin
          if (cfg_valid) begin
            kernel_flat[int'(kidx)*DATA_W +: DATA_W] <= cfg_data;
            if (kidx == 4'd8) begin
              kidx  <= '0;
              state <= STREAM;
            end else begin
              kidx <= kidx + 4'd1;
            end
          end
        end

        STREAM: begin
          if (rd_en) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (last_rd) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (out_count == exp_cnt) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Result beats outside the streaming window belong to no frame.
      if ((state == STREAM || state == DRAIN) && conv_out_valid)
        out_count <= out_count + (2*DIM_W)'(1);
    end
  end

endmodule
